// File: rtl/param_register_file.sv
// ---------------------------------------------------------------------------
// param_register_file
//
// Multi-read-port register file for the CPU datapath. Decode reads operands
// and marks issued destinations busy; writeback writes results and clears
// the matching busy bit. Reads are combinational and can see the data and
// busy-clear of a write happening in the same cycle (BYPASS). Register 0 can
// be hardwired to zero (ZERO_REG). A soft clear walks the array and zeroes
// one entry per cycle, during which writes, issues and further soft clears
// are ignored.
//
// Ports
//   CPU_CLOCK         clock, rising edge
//   CLEAR             asynchronous active-high reset
//   READ_REG          NUM_READ packed read indices (port k at [k*ADDR_W +: ADDR_W])
//   READ_DATA         NUM_READ packed read results (port k at [k*DATA_W +: DATA_W])
//   READ_BUSY         per read port: indexed register has a pending write
//   WRITE_REG/DATA    writeback index and data
//   REG_WRITE_ENABLE  writeback strobe
//   ISSUE_VALID/REG   mark a destination register busy
//   SOFT_CLEAR        start a zeroing sweep
//   SWEEP_ACTIVE      high while the sweep runs (DEPTH cycles)
//   BUSY_COUNT        registered number of busy registers
// ---------------------------------------------------------------------------
module param_register_file #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 4,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                         CPU_CLOCK,
    input  logic                         CLEAR,
    input  logic [NUM_READ*ADDR_W-1:0]   READ_REG,
    output logic [NUM_READ*DATA_W-1:0]   READ_DATA,
    output logic [NUM_READ-1:0]          READ_BUSY,
    input  logic [ADDR_W-1:0]            WRITE_REG,
    input  logic [DATA_W-1:0]            WRITE_DATA,
    input  logic                         REG_WRITE_ENABLE,
    input  logic                         ISSUE_VALID,
    input  logic [ADDR_W-1:0]            ISSUE_REG,
    input  logic                         SOFT_CLEAR,
    output logic                         SWEEP_ACTIVE,
    output logic [ADDR_W:0]              BUSY_COUNT
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic [ADDR_W-1:0]   sweep_idx_q, sweep_idx_d;
    logic [ADDR_W:0]     busy_count_q, busy_count_d;

    logic idle;
    logic write_accept;
    logic issue_accept;

    // Writes and issues only take effect while idle; with ZERO_REG the
    // zero register can neither be written nor marked busy.
    assign idle         = (state_q == ST_IDLE);
    assign write_accept = REG_WRITE_ENABLE && idle &&
                          !((ZERO_REG != 0) && (WRITE_REG == '0));
    assign issue_accept = ISSUE_VALID && idle &&
                          !((ZERO_REG != 0) && (ISSUE_REG == '0));

    // Read ports. Because write_accept already requires IDLE, forwarding is
    // naturally disabled during a sweep and reads see the stored contents.
    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0] rd_idx;
        logic              zero_hit;
        logic              fwd_hit;

        assign rd_idx   = READ_REG[k*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (rd_idx == '0);
        assign fwd_hit  = (BYPASS != 0) && write_accept && (WRITE_REG == rd_idx);

        assign READ_DATA[k*DATA_W +: DATA_W] = zero_hit ? '0 :
                                               fwd_hit  ? WRITE_DATA :
                                                          regs_q[rd_idx];
        assign READ_BUSY[k] = !zero_hit && !fwd_hit && busy_q[rd_idx];
    end

    // Next-state logic for the array, the busy scoreboard and the sweep FSM.
    // In IDLE the write is applied first so an issue to the same register in
    // the same cycle leaves it busy. SOFT_CLEAR wipes every busy bit on the
    // same edge, so it also overrides a coincident issue; a coincident write
    // still lands and is zeroed later by the sweep.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        busy_d      = busy_q;
        sweep_idx_d = sweep_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (write_accept) begin
                    regs_d[WRITE_REG] = WRITE_DATA;
                    busy_d[WRITE_REG] = 1'b0;
                end
                if (SOFT_CLEAR) begin
                    busy_d      = '0;
                    sweep_idx_d = '0;
                    state_d     = ST_SWEEP;
                end else if (issue_accept) begin
                    busy_d[ISSUE_REG] = 1'b1;
                end
            end
            ST_SWEEP: begin
                regs_d[sweep_idx_q] = '0;
                sweep_idx_d         = sweep_idx_q + 1'b1;
                if (sweep_idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Popcount of the next busy vector, so the registered count lines up
    // with the busy bits it describes.
    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_count_d = busy_count_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge CPU_CLOCK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            sweep_idx_q  <= '0;
            busy_count_q <= '0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            sweep_idx_q  <= sweep_idx_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign SWEEP_ACTIVE = (state_q == ST_SWEEP);
    assign BUSY_COUNT   = busy_count_q;

endmodule

// File: tb/tb_param_register_file.sv
// ---------------------------------------------------------------------------
// tb_param_register_file
//
// Drives two register files from the same stimulus: one with default
// parameters (bypass on, no zero register) and one with ZERO_REG=1. A
// behavioural model (plain arrays plus a sweep countdown) predicts read
// data, busy flags, sweep status and busy count every cycle.
// ---------------------------------------------------------------------------
module tb_param_register_file;

   localparam int DW    = 18;
   localparam int AW    = 4;
   localparam int NR    = 2;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              clear;
   logic [NR*AW-1:0]  read_reg;
   logic [AW-1:0]     write_reg;
   logic [DW-1:0]     write_data;
   logic              we;
   logic              iv;
   logic [AW-1:0]     issue_reg;
   logic              sc;

   logic [NR*DW-1:0]  rdata_a, rdata_b;
   logic [NR-1:0]     rbusy_a, rbusy_b;
   logic              sweep_a, sweep_b;
   logic [AW:0]       cnt_a, cnt_b;

   int checks;
   int errors;

   // Model state: register contents and busy flags per instance, plus the
   // number of sweep cycles still to run and the next entry to zero.
   logic [DW-1:0] m_mem  [2][DEPTH];
   bit            m_busy [2][DEPTH];
   int            sweep_left;
   int            sweep_pos;

   always #5 clk = ~clk;

   param_register_file #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(0), .BYPASS(1)
   ) dut_a (
      .CPU_CLOCK(clk), .CLEAR(clear), .READ_REG(read_reg),
      .READ_DATA(rdata_a), .READ_BUSY(rbusy_a),
      .WRITE_REG(write_reg), .WRITE_DATA(write_data),
      .REG_WRITE_ENABLE(we), .ISSUE_VALID(iv), .ISSUE_REG(issue_reg),
      .SOFT_CLEAR(sc), .SWEEP_ACTIVE(sweep_a), .BUSY_COUNT(cnt_a)
   );

   param_register_file #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)
   ) dut_z (
      .CPU_CLOCK(clk), .CLEAR(clear), .READ_REG(read_reg),
      .READ_DATA(rdata_b), .READ_BUSY(rbusy_b),
      .WRITE_REG(write_reg), .WRITE_DATA(write_data),
      .REG_WRITE_ENABLE(we), .ISSUE_VALID(iv), .ISSUE_REG(issue_reg),
      .SOFT_CLEAR(sc), .SWEEP_ACTIVE(sweep_b), .BUSY_COUNT(cnt_b)
   );

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[z][i]  = '0;
            m_busy[z][i] = 1'b0;
         end
      end
      sweep_left = 0;
      sweep_pos  = 0;
   endtask

   function automatic bit writeAccepted(int z);
      return we && (sweep_left == 0) && !(z == 1 && write_reg == '0);
   endfunction

   function automatic logic [DW-1:0] expData(int z, logic [AW-1:0] idx);
      if (z == 1 && idx == '0) return '0;
      if (writeAccepted(z) && write_reg == idx) return write_data;
      return m_mem[z][idx];
   endfunction

   function automatic bit expBusy(int z, logic [AW-1:0] idx);
      if (z == 1 && idx == '0) return 1'b0;
      if (writeAccepted(z) && write_reg == idx) return 1'b0;
      return m_busy[z][idx];
   endfunction

   function automatic int busyCount(int z);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += int'(m_busy[z][i]);
      return n;
   endfunction

   // Compare every output of both instances against the model.
   task automatic checkAll(input string phase);
      for (int z = 0; z < 2; z++) begin
         for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] idx;
            logic [DW-1:0] obs_d;
            logic          obs_b;
            idx   = read_reg[k*AW +: AW];
            obs_d = (z == 1) ? rdata_b[k*DW +: DW] : rdata_a[k*DW +: DW];
            obs_b = (z == 1) ? rbusy_b[k] : rbusy_a[k];
            checkOutput($sformatf("%s.z%0d.data%0d.r%0d", phase, z, k, idx),
                        32'(obs_d), 32'(expData(z, idx)));
            checkOutput($sformatf("%s.z%0d.busy%0d.r%0d", phase, z, k, idx),
                        32'(obs_b), 32'(expBusy(z, idx)));
         end
         checkOutput($sformatf("%s.z%0d.sweep", phase, z),
                     32'((z == 1) ? sweep_b : sweep_a), 32'(sweep_left > 0));
         checkOutput($sformatf("%s.z%0d.count", phase, z),
                     32'((z == 1) ? cnt_b : cnt_a), 32'(busyCount(z)));
      end
   endtask

   // Effect of one rising edge on the model, using the inputs held across it.
   task automatic modelEdge();
      if (sweep_left == 0) begin
         for (int z = 0; z < 2; z++) begin
            if (writeAccepted(z)) begin
               m_mem[z][write_reg]  = write_data;
               m_busy[z][write_reg] = 1'b0;
            end
         end
         if (sc) begin
            for (int z = 0; z < 2; z++)
               for (int i = 0; i < DEPTH; i++) m_busy[z][i] = 1'b0;
            sweep_left = DEPTH;
            sweep_pos  = 0;
         end else if (iv) begin
            for (int z = 0; z < 2; z++)
               if (!(z == 1 && issue_reg == '0)) m_busy[z][issue_reg] = 1'b1;
         end
      end else begin
         for (int z = 0; z < 2; z++) m_mem[z][sweep_pos] = '0;
         sweep_pos++;
         sweep_left--;
      end
   endtask

   // Drive one cycle's inputs on the falling edge and check outputs 1ns later.
   task automatic applyStimulus(input bit w, input logic [AW-1:0] wr,
                                input logic [DW-1:0] wd, input bit i,
                                input logic [AW-1:0] ir, input bit s,
                                input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                input string phase);
      @(negedge clk);
      we         = w;
      write_reg  = wr;
      write_data = wd;
      iv         = i;
      issue_reg  = ir;
      sc         = s;
      read_reg   = {r1, r0};
      #1;
      checkAll(phase);
   endtask

   task automatic tick();
      @(posedge clk);
      modelEdge();
   endtask

   task automatic runCycle(input bit w, input logic [AW-1:0] wr,
                           input logic [DW-1:0] wd, input bit i,
                           input logic [AW-1:0] ir, input bit s,
                           input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input string phase);
      applyStimulus(w, wr, wd, i, ir, s, r0, r1, phase);
      tick();
   endtask

   task automatic randomCycle(input bit allow_clear, input string phase);
      runCycle(bit'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
               DW'($urandom), bit'($urandom_range(0, 1)),
               AW'($urandom_range(0, DEPTH - 1)),
               allow_clear && ($urandom_range(0, 39) == 0),
               AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
               phase);
   endtask

   int sweep_seen;

   initial begin
      checks     = 0;
      errors     = 0;
      clear      = 1'b1;
      we         = 1'b0;
      iv         = 1'b0;
      sc         = 1'b0;
      write_reg  = '0;
      write_data = '0;
      issue_reg  = '0;
      read_reg   = '0;
      modelReset();

      #2;
      checkAll("reset");
      @(negedge clk);
      read_reg = {4'd7, 4'd3};
      #1;
      checkAll("reset2");
      @(negedge clk);
      clear = 1'b0;

      // Write R3 (forwarded in-cycle), then read it back from storage.
      applyStimulus(1, 4'd3, 18'h2ABCD, 0, 4'd0, 0, 4'd3, 4'd4, "w3");
      checkOutput("w3_bypass", 32'(rdata_a[DW-1:0]), 32'h2ABCD);
      tick();
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd3, 4'd1, "r3");
      checkOutput("r3_port0", 32'(rdata_a[DW-1:0]), 32'h2ABCD);
      checkOutput("r1_port1", 32'(rdata_a[2*DW-1:DW]), 32'h0);
      tick();

      // Same-cycle write/read of R5.
      applyStimulus(1, 4'd5, 18'h00123, 0, 4'd0, 0, 4'd2, 4'd5, "w5");
      checkOutput("w5_bypass", 32'(rdata_a[2*DW-1:DW]), 32'h00123);
      tick();

      // Write and issue R0: hardwired zero instance ignores both.
      runCycle(1, 4'd0, 18'h3FFFF, 1, 4'd0, 0, 4'd0, 4'd0, "w0");
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd0, 4'd0, "r0");
      checkOutput("z_r0_data", 32'(rdata_b[DW-1:0]), 32'h0);
      checkOutput("z_r0_busy", 32'(rbusy_b[0]), 32'h0);
      checkOutput("z_count0", 32'(cnt_b), 32'h0);
      checkOutput("a_r0_data", 32'(rdata_a[DW-1:0]), 32'h3FFFF);
      tick();

      // Scoreboard: issue R2, R7; retire R2; issue+write R7 together.
      runCycle(0, 4'd0, 18'h0, 1, 4'd2, 0, 4'd2, 4'd7, "i2");
      runCycle(0, 4'd0, 18'h0, 1, 4'd7, 0, 4'd2, 4'd7, "i7");
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd2, 4'd7, "busy2");
      checkOutput("z_count2", 32'(cnt_b), 32'd2);
      checkOutput("z_busy_r2", 32'(rbusy_b[0]), 32'h1);
      tick();
      runCycle(1, 4'd2, 18'h00222, 0, 4'd0, 0, 4'd2, 4'd7, "w2");
      applyStimulus(1, 4'd7, 18'h00777, 1, 4'd7, 0, 4'd2, 4'd7, "iw7");
      checkOutput("z_count1", 32'(cnt_b), 32'd1);
      tick();
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd7, 4'd2, "after_iw7");
      checkOutput("z_busy_r7", 32'(rbusy_b[0]), 32'h1);
      checkOutput("z_data_r7", 32'(rdata_b[DW-1:0]), 32'h00777);
      checkOutput("z_count1b", 32'(cnt_b), 32'd1);
      tick();

      // Randomised traffic including occasional soft clears.
      for (int n = 0; n < 500; n++) randomCycle(1'b1, "rand");

      // Let any sweep still running finish.
      for (int n = 0; n < DEPTH + 1 && sweep_left > 0; n++)
         runCycle(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd0, 4'd1, "drain");

      // Fill every register, then soft clear together with a write.
      for (int i = 0; i < DEPTH; i++)
         runCycle(1, AW'(i), DW'($urandom) | 18'h1, 1, AW'(i), 0,
                  AW'(i), AW'(i ^ 1), "fill");
      runCycle(1, 4'd6, 18'h15555, 0, 4'd0, 1, 4'd6, 4'd6, "sclr");
      sweep_seen = 0;
      for (int n = 0; n < DEPTH + 2; n++) begin
         if (n < DEPTH)
            applyStimulus(bit'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                          DW'($urandom), bit'($urandom_range(0, 1)),
                          AW'($urandom_range(0, DEPTH - 1)), bit'($urandom_range(0, 1)),
                          AW'($urandom_range(0, DEPTH - 1)),
                          AW'($urandom_range(0, DEPTH - 1)), "sweep");
         else
            applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd6, 4'd0, "post");
         if (sweep_a) sweep_seen++;
         tick();
      end
      checkOutput("sweep_len", 32'(sweep_seen), 32'(DEPTH));
      for (int i = 0; i < DEPTH / 2; i++) begin
         applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, AW'(2 * i), AW'(2 * i + 1), "zeroed");
         checkOutput($sformatf("zeroed_r%0d", 2 * i), 32'(rdata_a), 32'h0);
         tick();
      end
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd0, 4'd0, "count_after");
      checkOutput("count_after_sweep", 32'(cnt_a), 32'h0);
      tick();

      // Abandon a sweep with CLEAR partway through.
      for (int i = 0; i < 4; i++)
         runCycle(1, AW'(8 + i), DW'($urandom) | 18'h1, 0, 4'd0, 0,
                  AW'(8 + i), 4'd0, "fill2");
      runCycle(0, 4'd0, 18'h0, 0, 4'd0, 1, 4'd9, 4'd10, "sclr2");
      for (int n = 0; n < 5; n++)
         runCycle(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd9, 4'd10, "sweep2");
      @(negedge clk);
      we       = 1'b0;
      iv       = 1'b0;
      sc       = 1'b0;
      read_reg = {4'd11, 4'd10};
      clear    = 1'b1;
      #1;
      modelReset();
      checkAll("midclear");
      checkOutput("midclear_sweep", 32'(sweep_a), 32'h0);
      checkOutput("midclear_r11", 32'(rdata_a[2*DW-1:DW]), 32'h0);
      @(negedge clk);
      clear = 1'b0;
      runCycle(1, 4'd9, 18'h00001, 0, 4'd0, 0, 4'd9, 4'd8, "w9");
      applyStimulus(0, 4'd0, 18'h0, 0, 4'd0, 0, 4'd9, 4'd8, "r9");
      checkOutput("r9_after_clear", 32'(rdata_a[DW-1:0]), 32'h1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
